mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port program/data memory between the CPU sequencing controller (fetch, load, store) and a DMA/IO requester.
- Serialises the two requesters and drives one memory transaction at a time.
- Handshakes with a variable-latency memory through mem_ready.
- Returns read data and a completion pulse to whichever requester owns the transaction.

Parameters:
- ADDR_W, 6, memory address width in bits.
- DATA_W, 8, memory data width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cpu_req  input  1  CPU requests one access.
- cpu_we  input  1  CPU access type: 1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU access address.
- cpu_wdata  input  DATA_W  CPU write data.
- cpu_gnt  output  1  one-cycle pulse: CPU request accepted.
- cpu_done  output  1  one-cycle pulse: CPU access complete.
- cpu_rdata  output  DATA_W  last CPU read data, held until the next CPU read completes.
- dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  same meaning as the CPU inputs, for DMA.
- dma_gnt, dma_done, dma_rdata  output  1/1/DATA_W  same meaning as the CPU outputs, for DMA.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the current access.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, ACCESS, DONE (2-bit encoding).
- Async reset, from any state including mid-ACCESS:
  - state=IDLE, owner=CPU, last_owner=DMA.
  - Latched we/addr/wdata = 0; cpu_rdata = dma_rdata = 0.
  - All strobes, gnt, done and busy = 0.
  - An in-flight memory access is abandoned; no done pulse is issued for it.
- IDLE:
  - Requests are sampled only in IDLE.
  - Any req=1 at a rising edge: winner chosen; winner's we/addr/wdata latched; owner=winner; next state ACCESS.
  - No req: stay in IDLE.
  - mem_ready is ignored.
- Arbitration (default build): 2-way round-robin. Sole requester wins. When both request, the one that is not last_owner wins, so after reset the CPU wins the first tie.
- ACCESS:
  - gnt of owner = 1 in the first ACCESS cycle only.
  - mem_rd = ~latched_we and mem_wr = latched_we, held for the whole state.
  - mem_addr and mem_wdata come from latched values and are stable for the whole state.
  - mem_ready=1 at an edge: for a read, mem_rdata is captured into the owner's rdata register; next state DONE.
  - mem_ready=0: stay in ACCESS, unbounded.
- DONE:
  - Owner's done = 1 for exactly one cycle; strobes = 0.
  - last_owner = owner; next state IDLE.
- Latency: req seen at edge k → gnt and strobe in cycle k+1 → ready at edge k+1 (best case) → done in cycle k+2 → IDLE at k+3. Minimum 3 cycles per access; at most one access is in flight.
- Requester rules:
  - Hold req and the access fields stable until gnt is seen.
  - Drop req in the cycle after gnt unless another access is wanted.
  - req still high when IDLE is re-entered is treated as a new request.
- Simultaneous events:
  - A req arriving in ACCESS or DONE is ignored until IDLE.
  - mem_ready arriving in DONE or IDLE is ignored.
  - Both req=1 is resolved by the arbitration rule.
- Non-owner outputs (gnt, done, rdata) are never disturbed by the other requester's transactions.
- mem_addr and mem_wdata may be 0 outside ACCESS.

Optional Feature:
- Macro: CPU_PRIORITY_EN.
- Defined: fixed priority. CPU always wins a tie; last_owner is still updated but not used. DMA can be starved while cpu_req stays high.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package mem_arb_pkg holds:
  - State encodings ST_IDLE=2'b00, ST_ACCESS=2'b01, ST_DONE=2'b10.
  - Owner constants OWN_CPU=1'b0, OWN_DMA=1'b1.
- Sub-module mem_arb_pick, combinational:
  - Inputs cpu_req, dma_req, last_owner; outputs valid, winner.
  - Contains the round-robin/priority logic, including the CPU_PRIORITY_EN switch.

Test Plan:
- Reset then single CPU read, addr=6'h05, mem_ready high in first ACCESS cycle, mem_rdata=8'hA5 → cpu_gnt 1 cycle after req, mem_rd=1 and mem_addr=05 for 1 cycle, cpu_done next cycle, cpu_rdata=A5, busy=1 for 2 cycles.
- DMA write, addr=6'h3F, wdata=8'h5C, mem_ready delayed 4 cycles → mem_wr=1 held for 5 cycles with addr/data stable; one dma_done; dma_rdata unchanged.
- Both requesters held high for 4 transactions under default build → grant order CPU, DMA, CPU, DMA.
- Same stimulus with CPU_PRIORITY_EN → all 4 grants go to the CPU; dma_gnt never asserted.
- Reset asserted asynchronously mid-ACCESS (mem_ready=0), then released → all outputs 0 immediately, no done pulse, next tie won by CPU.
- cpu_req rises during a DMA ACCESS → ignored until IDLE; cpu_gnt exactly 1 cycle after DMA DONE; stray mem_ready pulse in IDLE has no effect.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state and owner encodings shared by the memory port arbiter files.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; round-robin, or CPU-first when CPU_PRIORITY_EN is defined.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_owner,
  output logic valid,
  output logic winner
);
  assign valid = cpu_req | dma_req;
`ifdef CPU_PRIORITY_EN
  assign winner = cpu_req ? OWN_CPU : OWN_DMA;
`else
  assign winner = (cpu_req && dma_req) ? ~last_owner : (cpu_req ? OWN_CPU : OWN_DMA);
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises CPU and DMA accesses onto one variable-latency memory port.
// Arbitration mode selected by CPU_PRIORITY_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_done,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_owner_q, last_owner_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic cpu_gnt_q, cpu_gnt_d, dma_gnt_q, dma_gnt_d, cpu_done_q, cpu_done_d, dma_done_q, dma_done_d;
  logic mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, busy_q, busy_d;
  logic valid, winner, first;
  mem_arb_pick u_pick (
    .cpu_req   (cpu_req),
    .dma_req   (dma_req),
    .last_owner(last_owner_q),
    .valid     (valid),
    .winner    (winner)
  );
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    if (state_q == ST_IDLE && valid) begin
      state_d = ST_ACCESS;
      owner_d = winner;
      we_d    = winner == OWN_DMA ? dma_we : cpu_we;
      addr_d  = winner == OWN_DMA ? dma_addr : cpu_addr;
      wdata_d = winner == OWN_DMA ? dma_wdata : cpu_wdata;
    end
    if (state_q == ST_ACCESS && mem_ready) begin
      state_d     = ST_DONE;
      cpu_rdata_d = (!we_q && owner_q == OWN_CPU) ? mem_rdata : cpu_rdata_q;
      dma_rdata_d = (!we_q && owner_q == OWN_DMA) ? mem_rdata : dma_rdata_q;
    end
    if (state_q == ST_DONE) begin
      state_d      = ST_IDLE;
      last_owner_d = owner_q;
    end
    // Outputs are registered from next-state values so they line up with the state they describe.
    first      = state_q == ST_IDLE && state_d == ST_ACCESS;
    cpu_gnt_d  = first && owner_d == OWN_CPU;
    dma_gnt_d  = first && owner_d == OWN_DMA;
    mem_rd_d   = state_d == ST_ACCESS && !we_d;
    mem_wr_d   = state_d == ST_ACCESS && we_d;
    cpu_done_d = state_d == ST_DONE && owner_d == OWN_CPU;
    dma_done_d = state_d == ST_DONE && owner_d == OWN_DMA;
    busy_d     = state_d != ST_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_DMA;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      dma_done_q   <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dma_gnt_q    <= dma_gnt_d;
      cpu_done_q   <= cpu_done_d;
      dma_done_q   <= dma_done_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      busy_q       <= busy_d;
    end
  end
  assign cpu_gnt   = cpu_gnt_q;
  assign dma_gnt   = dma_gnt_q;
  assign cpu_done  = cpu_done_q;
  assign dma_done  = dma_done_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;
endmodule
